piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter, the opposite end of the team's serial-in shift register chain. It accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding buffer, then shifts each word out one bit per bit-rate enable tick. Consecutive words stream with no gap bit. It sits between word-level producer logic and a single-wire serial link whose receiver is a shift register clocked on the same enable.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
// Holds the two-state FSM encoding and the bit-counter width helper.
// No logic lives here; only types and elaboration-time functions.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit counter width for a word of the given size (at least one bit).
    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-entry holding buffer.
// Latency: accept at edge n, transfer at n+1, first bit on the first shift_en edge after n+1.
// Backpressure: din_ready is low while a word is held; words stream gap-free on shift_en.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int             CW   = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             din_ready_q, din_ready_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;

    // Next-state: transfer hold into the shifter, shift one bit per tick, accept new words.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // shift_en is ignored here; a held word moves straight into the shifter.
                if (hold_full_q) begin
                    sr_d        = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (MSB_FIRST) begin
                        dout_d = sr_q[WIDTH-1];
                        sr_d   = {sr_q[WIDTH-2:0], 1'b0};
                    end else begin
                        dout_d = sr_q[0];
                        sr_d   = {1'b0, sr_q[WIDTH-1:1]};
                    end
                    dout_valid_d  = 1'b1;
                    frame_start_d = (cnt_q == '0);
                    done_d        = (cnt_q == LAST);
                    cnt_d         = cnt_q + CW'(1);
                    // Last bit: chain straight into the held word so there is no gap bit.
                    if (cnt_q == LAST) begin
                        if (hold_full_q) begin
                            sr_d        = hold_q;
                            cnt_d       = '0;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only when empty, so it can never collide with a transfer.
        if (din_valid && din_ready_q) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end

        din_ready_d = !hold_full_d;
    end

    // State and output registers; clr discards both words and restores idle outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            sr_q          <= '0;
            cnt_q         <= '0;
            din_ready_q   <= 1'b1;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            din_ready_q   <= din_ready_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign din_ready   = din_ready_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
    assign busy        = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one stimulus stream.
// Reference model tracks the current word and bit position, not a shift register.
// Directed steps first, then a randomized run with occasional mid-frame clears.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         shift_en = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic din_ready_m, dout_m, dout_valid_m, frame_start_m, done_m, busy_m;
    logic din_ready_l, dout_l, dout_valid_l, frame_start_l, done_l, busy_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clr(clr), .shift_en(shift_en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_m), .dout(dout_m), .dout_valid(dout_valid_m),
        .frame_start(frame_start_m), .done(done_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clr(clr), .shift_en(shift_en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
        .frame_start(frame_start_l), .done(done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a word being sent (m_word, next bit index m_k) plus one held word.
    bit         m_active;
    logic [W-1:0] m_word;
    int         m_k;
    logic [W-1:0] m_hold;
    bit         m_full;
    logic       m_dout_m, m_dout_l, m_vld, m_fs, m_done;

    // Observed serial streams and pulse counts for directed checks.
    logic [15:0] col_m, col_l;
    int          n_vld, n_fs, n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_word = '0; m_k = 0; m_hold = '0; m_full = 0;
        m_dout_m = 0; m_dout_l = 0; m_vld = 0; m_fs = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit old_full;
        old_full = m_full;
        m_vld = 0; m_fs = 0; m_done = 0;
        if (m_active) begin
            if (shift_en) begin
                m_dout_m = m_word[W-1-m_k];
                m_dout_l = m_word[m_k];
                m_vld    = 1;
                m_fs     = (m_k == 0);
                m_done   = (m_k == W-1);
                m_k++;
                if (m_k == W) begin
                    if (old_full) begin
                        m_word = m_hold; m_k = 0; m_full = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end
        end else if (old_full) begin
            m_word = m_hold; m_k = 0; m_full = 0; m_active = 1;
        end
        if (din_valid && !old_full) begin
            m_hold = din;
            m_full = 1;
        end
    endtask

    task automatic check_outputs();
        chk("dout_msb",   dout_m,       m_dout_m);
        chk("dout_lsb",   dout_l,       m_dout_l);
        chk("vld_msb",    dout_valid_m, m_vld);
        chk("vld_lsb",    dout_valid_l, m_vld);
        chk("fs_msb",     frame_start_m, m_fs);
        chk("fs_lsb",     frame_start_l, m_fs);
        chk("done_msb",   done_m,       m_done);
        chk("done_lsb",   done_l,       m_done);
        chk("ready_msb",  din_ready_m,  !m_full);
        chk("ready_lsb",  din_ready_l,  !m_full);
        chk("busy_msb",   busy_m,       m_active || m_full);
        chk("busy_lsb",   busy_l,       m_active || m_full);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (clr) model_reset();
        else     model_edge();
        @(negedge clk);
        check_outputs();
        if (dout_valid_m) begin
            col_m = {col_m[14:0], dout_m};
            col_l = {col_l[14:0], dout_l};
            n_vld++;
            if (frame_start_m) n_fs++;
            if (done_m)        n_done++;
        end
    endtask

    task automatic clear_col();
        col_m = '0; col_l = '0; n_vld = 0; n_fs = 0; n_done = 0;
    endtask

    initial begin
        model_reset();
        clear_col();

        // Reset state
        @(negedge clk);
        chk("rst_dout",  dout_m, 1'b0);
        chk("rst_vld",   dout_valid_m, 1'b0);
        chk("rst_fs",    frame_start_m, 1'b0);
        chk("rst_done",  done_m, 1'b0);
        chk("rst_busy",  busy_m, 1'b0);
        chk("rst_ready", din_ready_m, 1'b1);
        step();
        clr = 1'b0;
        step();

        // Single word 1011, shift_en always high
        clear_col();
        shift_en = 1'b1; din = 4'b1011; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        chk("lat_no_bit_yet", n_vld, 0);
        step();
        chk("lat_first_fs", frame_start_m, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("w1_bits_msb", col_m[3:0], 4'b1011);
        chk("w1_bits_lsb", col_l[3:0], 4'b1101);
        chk("w1_nfs", n_fs, 1);
        chk("w1_ndone", n_done, 1);
        chk("w1_idle_busy", busy_m, 1'b0);

        // Back-to-back 1011 then 0110 with din_valid held
        clear_col();
        din = 4'b1011; din_valid = 1'b1;
        step();
        din = 4'b0110;
        step();
        step();
        chk("b2b_ready_held", din_ready_m, 1'b0);
        din_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("b2b_bits", col_m[7:0], 8'b10110110);
        chk("b2b_nvld", n_vld, 8);
        chk("b2b_nfs", n_fs, 2);
        chk("b2b_ndone", n_done, 2);

        // shift_en every 3rd cycle, word 1001
        clear_col();
        shift_en = 1'b0; din = 4'b1001; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shift_en = (i % 3 == 0);
            step();
        end
        chk("slow_bits", col_m[3:0], 4'b1001);
        chk("slow_nvld", n_vld, 4);

        // LSB-first instance, word 1101 -> 1,0,1,1
        clear_col();
        shift_en = 1'b1; din = 4'b1101; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("lsb_bits", col_l[3:0], 4'b1011);

        // din changes while a word is held: only the accepted value goes out
        clear_col();
        shift_en = 1'b0; din = 4'b0011; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        din = 4'b1100; din_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            din = W'($urandom);
            step();
        end
        din_valid = 1'b0; shift_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("held_bits", col_m[7:0], 8'b00111100);

        // clr after the 2nd bit of 1111 with 1010 held
        clear_col();
        din = 4'b1111; din_valid = 1'b1;
        step();
        step();
        din = 4'b1010;
        step();
        din_valid = 1'b0;
        step();
        chk("clr_pre_bits", n_vld, 2);
        clr = 1'b1;
        #1;
        chk("clr_dout",  dout_m, 1'b0);
        chk("clr_vld",   dout_valid_m, 1'b0);
        chk("clr_fs",    frame_start_m, 1'b0);
        chk("clr_done",  done_m, 1'b0);
        chk("clr_busy",  busy_m, 1'b0);
        chk("clr_ready", din_ready_m, 1'b1);
        step();
        clr = 1'b0;
        clear_col();
        for (int i = 0; i < 8; i++) step();
        chk("clr_no_vld", n_vld, 0);
        chk("clr_ready_after", din_ready_m, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            shift_en  = ($urandom_range(0, 3) != 0);
            din_valid = ($urandom_range(0, 2) != 0);
            din       = W'($urandom);
            clr       = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
